// File: rtl/decode_arb_pkg.sv
// decode_arbiter shared types and helpers.
// Optional burst lock is enabled by defining DECODE_ARB_LOCK_EN.
package decode_arb_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int ID_W_DEF     = $clog2(NUM_REQ_DEF);
  localparam int LOCK_MAX_DEF = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  function automatic logic [3:0] decode2(
    input logic a,
    input logic b
  );
    return {a & b, a & ~b, a ^ b, b};
  endfunction

  // Search ptr, ptr+1, ... wrapping at n; vectors sized for n <= 8.
  function automatic logic [7:0] rr_pick(
    input logic [7:0] vld,
    input logic [2:0] ptr,
    input int         n
  );
    logic [7:0] g;
    logic       found;
    int         j;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && !found && vld[3'(j)]) begin
        g[3'(j)] = 1'b1;
        found    = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/decode_arbiter_ab_decode_stage.sv
// Registered 2-bit operand pair feeding the combinational decoder.
// Used by decode_arbiter (DECODE_ARB_LOCK_EN has no effect here).
module ab_decode_stage
  import decode_arb_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       a_d,
  input  logic       b_d,
  output logic [3:0] y
);

  logic a_q, b_q;
  logic a_n, b_n;

  always_comb begin
    a_n = a_q;
    b_n = b_q;
    if (en) begin
      a_n = a_d;
      b_n = b_d;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      a_q <= a_n;
      b_q <= b_n;
    end
  end

  assign y = decode2(a_q, b_q);

endmodule

// File: rtl/decode_arbiter.sv
// Round-robin arbiter sharing one registered decode stage.
// Define DECODE_ARB_LOCK_EN to enable per-requester burst lock.
module decode_arbiter
  import decode_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0] req_lock,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [3:0]         rsp_y
);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    gidx, nxt;
  logic [NUM_REQ-1:0] grant;
  logic [7:0]         pick;
  logic               can_acc, xfer;
  logic               a_d, b_d;

  // Grant is gated by clr so req_ready drops the moment reset asserts.
  always_comb begin
    can_acc = clr & ((state_q == EMPTY) | rsp_ready);
    pick    = rr_pick(8'(req_valid), 3'(ptr_q), NUM_REQ);
    grant   = can_acc ? pick[NUM_REQ-1:0] : '0;
    xfer    = |grant;
    gidx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = ID_W'(i);
    end
    nxt = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
    a_d = |(req_a & grant);
    b_d = |(req_b & grant);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    if (xfer) begin
      state_d = FULL;
      id_d    = gidx;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

`ifdef DECODE_ARB_LOCK_EN
  localparam int LCW = $clog2(LOCK_MAX + 1);

  logic [LCW-1:0] lock_q, lock_d, cnt_n;
  logic           lk;

  // A nonzero count means ptr_q is parked on the lock owner.
  always_comb begin
    ptr_d  = ptr_q;
    lock_d = lock_q;
    lk     = |(req_lock & grant);
    cnt_n  = (gidx == ptr_q && lock_q != '0) ?
             lock_q + LCW'(1) : LCW'(1);
    if (xfer) begin
      if (lk && cnt_n != LCW'(LOCK_MAX)) begin
        ptr_d  = gidx;
        lock_d = cnt_n;
      end else begin
        ptr_d  = nxt;
        lock_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) lock_q <= '0;
    else      lock_q <= lock_d;
  end
`else
  localparam int unused_lock_max = LOCK_MAX;
  logic unused_lock;

  assign unused_lock = ^req_lock;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = nxt;
  end
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
    end
  end

  ab_decode_stage u_dec (
    .clk (clk),
    .clr (clr),
    .en  (xfer),
    .a_d (a_d),
    .b_d (b_d),
    .y   (rsp_y)
  );

  assign req_ready = grant;
  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_decode_arbiter.sv
// Self-checking bench for decode_arbiter.
// Lock scenario runs only when DECODE_ARB_LOCK_EN is defined.
module tb_decode_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int LM = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_a = '0;
  logic [N-1:0]  req_b = '0;
  logic [N-1:0]  req_lock = '0;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [IW-1:0] rsp_id;
  logic [3:0]    rsp_y;

  int tests = 0;
  int fails = 0;
  int glog[$];
  int exp_rr[6] = '{0, 1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  decode_arbiter #(
    .NUM_REQ  (N),
    .ID_W     (IW),
    .LOCK_MAX (LM)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Truth table of the decoder, by operand pair {a,b}.
  function automatic int ydec(input logic a, input logic b);
    if (!a && !b) return 0;
    if (!a &&  b) return 3;
    if ( a && !b) return 6;
    return 9;
  endfunction

  // Reference model: pointer, held result, lock run length.
  int m_ptr, m_id, m_y, m_lock, m_g;
  bit m_full;

  always_comb begin
    int idx;
    idx = 0;
    m_g = -1;
    if (clr && !(m_full && !rsp_ready)) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (m_ptr + k) % N;
        if (req_valid[idx]) m_g = idx;
      end
    end
  end

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_ptr  <= 0;
      m_full <= 0;
      m_id   <= 0;
      m_y    <= 0;
      m_lock <= 0;
    end else if (m_g >= 0) begin
      m_full <= 1;
      m_id   <= m_g;
      m_y    <= ydec(req_a[m_g], req_b[m_g]);
`ifdef DECODE_ARB_LOCK_EN
      if (req_lock[m_g]) begin
        if (((m_g == m_ptr && m_lock > 0) ? m_lock + 1 : 1) >= LM) begin
          m_ptr  <= (m_g + 1) % N;
          m_lock <= 0;
        end else begin
          m_ptr  <= m_g;
          m_lock <= (m_g == m_ptr && m_lock > 0) ? m_lock + 1 : 1;
        end
      end else begin
        m_ptr  <= (m_g + 1) % N;
        m_lock <= 0;
      end
`else
      m_ptr <= (m_g + 1) % N;
`endif
    end else if (m_full && rsp_ready) begin
      m_full <= 0;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    chk("rsp_id", 32'(rsp_id), m_id);
    chk("rsp_y", 32'(rsp_y), m_y);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && req_valid[i]) glog.push_back(i);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    req_valid = '1;
    step(2);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    clr       = 1'b1;
    req_a     = 4'b1010;
    req_b     = 4'b1100;
    rsp_ready = 1'b1;
    glog.delete();
    step(6);
    chk("rr_len", glog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("rr_order", (glog.size() > i) ? glog[i] : -1, exp_rr[i]);
    end

    rsp_ready = 1'b0;
    step(3);
    chk("bp_ready", 32'(req_ready), 0);
    chk("bp_id", 32'(rsp_id), 1);
    chk("bp_y", 32'(rsp_y), 6);
    chk("bp_valid", 32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release", 32'(req_ready), 4'b0100);
    step(1);
    req_valid = '0;
    step(1);
    chk("drain", 32'(rsp_valid), 0);

    req_valid = 4'b0100;
    for (int p = 0; p < 4; p++) begin
      req_a[2] = p[1];
      req_b[2] = p[0];
      step(1);
      chk("tt_y", 32'(rsp_y), (p == 0) ? 0 : (p == 1) ? 3 : (p == 2) ? 6 : 9);
      chk("tt_id", 32'(rsp_id), 2);
    end
    req_valid = '0;
    step(1);

    req_valid = 4'b0010;
    step(1);
    req_valid = 4'b1010;
    glog.delete();
    step(2);
    chk("sp_len", glog.size(), 2);
    chk("sp_first", (glog.size() > 0) ? glog[0] : -1, 3);
    chk("sp_second", (glog.size() > 1) ? glog[1] : -1, 1);
    req_valid = '0;
    step(1);

`ifdef DECODE_ARB_LOCK_EN
    req_valid = 4'b0011;
    req_lock  = 4'b0001;
    glog.delete();
    step(5);
    chk("lk_len", glog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("lk_order", (glog.size() > i) ? glog[i] : -1, (i < 4) ? 0 : 1);
    end
    req_valid = '0;
    req_lock  = '0;
    step(1);
`endif

    req_valid = '1;
    step(1);
    #2;
    clr = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_y", 32'(rsp_y), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_id", 32'(rsp_id), 0);
    step(1);
    clr = 1'b1;
    glog.delete();
    step(1);
    chk("rst_first_len", 32'(glog.size() > 0), 1);
    chk("rst_first", (glog.size() > 0) ? glog[0] : -1, 0);
    req_valid = '0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
